// File: rtl/mod_updown_counter.sv
// Up/down modulo-MOD_VAL counter: sync clear, clamped load, wrap or saturate, tc pulse, sticky boundary flag.
// Registered outputs, 1-cycle latency, no backpressure; COUNTER_PRESCALE_EN adds an en-cycle prescaler.
module mod_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD_VAL  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             bound_flg
);

  // One extra bit so MOD_VAL == 2**WIDTH compares without truncation.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MOD_VAL - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  if (WIDTH < 1 || MOD_VAL < 2 || longint'(MOD_VAL) > (64'sd1 <<< WIDTH)) begin : g_bad_mod
    $error("mod_updown_counter: MOD_VAL must lie in 2..2**WIDTH");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be at least 2");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             bound_q, bound_d;
  logic             step_en;
  logic             at_max;
  logic             at_zero;

  assign at_max  = ({1'b0, count_q} == MAX_EXT);
  assign at_zero = (count_q == '0);

`ifdef COUNTER_PRESCALE_EN
  localparam int            PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_q, ps_d;

  assign step_en = en && (ps_q == PS_LAST);

  always_comb begin
    ps_d = ps_q;
    if (clr || load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step_en = en;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    bound_d = bound_q;
    if (clr) begin
      count_d = '0;
      bound_d = 1'b0;
    end else if (load) begin
      count_d = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
    end else if (step_en) begin
      if (up_dn) begin
        if (at_max) begin
          tc_d    = 1'b1;
          bound_d = 1'b1;
          count_d = (SATURATE != 0) ? MAX_VAL : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (at_zero) begin
          tc_d    = 1'b1;
          bound_d = 1'b1;
          count_d = (SATURATE != 0) ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      bound_q <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      bound_q <= bound_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign bound_flg = bound_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: three counters (wrap mod 10, saturate mod 10, wrap mod 16) share one stimulus stream.
module tb_mod_updown_counter;

  localparam int PS = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam int DIV = PS;
`else
  localparam int DIV = 1;
`endif
  localparam int MODS [3] = '{10, 10, 16};
  localparam bit SATS [3] = '{1'b0, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] cnt_w, cnt_s, cnt_f;
  logic       tc_w, tc_s, tc_f, bnd_w, bnd_s, bnd_f;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(0), .PRESCALE(PS)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count_out(cnt_w), .tc(tc_w), .bound_flg(bnd_w));
  mod_updown_counter #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1), .PRESCALE(PS)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count_out(cnt_s), .tc(tc_s), .bound_flg(bnd_s));
  mod_updown_counter #(.WIDTH(4), .MOD_VAL(16), .SATURATE(0), .PRESCALE(PS)) u_full (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count_out(cnt_f), .tc(tc_f), .bound_flg(bnd_f));

  typedef struct packed {
    logic [2:0][3:0] cnt;
    logic [2:0]      tc;
    logic [2:0]      bnd;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_cnt [3];
  int   m_ps  [3];
  bit   m_bnd [3];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t sample();
    exp_t a;
    a.cnt = {cnt_f, cnt_s, cnt_w};
    a.tc  = {tc_f, tc_s, tc_w};
    a.bnd = {bnd_f, bnd_s, bnd_w};
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_ps[i]  = 0;
      m_bnd[i] = 1'b0;
    end
  endtask

  // Reference: count lives in 0..MOD-1; a step leaving that range is a boundary hit.
  task automatic model_edge(input bit e, input bit u, input bit c, input bit l, input int lv);
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      bit step;
      bit t;
      int nxt;
      t = 1'b0;
      if (c) begin
        m_cnt[i] = 0; m_bnd[i] = 1'b0; m_ps[i] = 0;
      end else if (l) begin
        m_cnt[i] = (lv < MODS[i]) ? lv : MODS[i] - 1;
        m_ps[i]  = 0;
      end else if (e) begin
        step = 1'b1;
`ifdef COUNTER_PRESCALE_EN
        m_ps[i]++;
        step = (m_ps[i] == PS);
        if (step) m_ps[i] = 0;
`endif
        if (step) begin
          nxt = m_cnt[i] + (u ? 1 : -1);
          if (nxt < 0 || nxt >= MODS[i]) begin
            t = 1'b1;
            m_bnd[i] = 1'b1;
            if (!SATS[i]) m_cnt[i] = (nxt + MODS[i]) % MODS[i];
          end else begin
            m_cnt[i] = nxt;
          end
        end
      end
      x.cnt[i] = 4'(m_cnt[i]);
      x.tc[i]  = t;
      x.bnd[i] = m_bnd[i];
    end
    sb_q.push_back(x);
  endtask

  task automatic drive(input bit e, input bit u, input bit c, input bit l, input int lv);
    @(negedge clk);
    en = e; up_dn = u; clr = c; load = l; load_val = 4'(lv);
    model_edge(e, u, c, l, lv);
  endtask

  task automatic check_all_zero(input string tag);
    exp_t a;
    a = sample();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s cnt[%0d]", tag, i), int'(a.cnt[i]), 0);
      check($sformatf("%s tc[%0d]", tag, i), int'(a.tc[i]), 0);
      check($sformatf("%s bnd[%0d]", tag, i), int'(a.bnd[i]), 0);
    end
  endtask

  // Monitor: every edge with an issued stimulus has one queued expectation.
  always @(posedge clk) begin
    exp_t ex;
    exp_t ac;
    #1;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      ac = sample();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cnt[%0d]", i), int'(ac.cnt[i]), int'(ex.cnt[i]));
        check($sformatf("tc[%0d]", i), int'(ac.tc[i]), int'(ex.tc[i]));
        check($sformatf("bnd[%0d]", i), int'(ac.bnd[i]), int'(ex.bnd[i]));
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;

    // Up wrap from 0, twelve steps.
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 12 * DIV; k++) drive(1, 1, 0, 0, 0);

    // Asynchronous reset mid-count, held across an enabled edge.
    drive(0, 0, 0, 1, 7);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    model_reset();

    // Down wrap with direction change.
    drive(0, 0, 0, 1, 1);
    for (int k = 0; k < 3 * DIV; k++) drive(1, 0, 0, 0, 0);
    for (int k = 0; k < DIV; k++) drive(1, 1, 0, 0, 0);

    // Saturate run at the top, then clear.
    drive(0, 0, 0, 1, 8);
    for (int k = 0; k < 4 * DIV; k++) drive(1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0);
    for (int k = 0; k < 2 * DIV; k++) drive(1, 0, 0, 0, 0);

    // Priority and clamping.
    drive(1, 1, 1, 1, 5);
    drive(1, 1, 0, 1, 12);
    drive(0, 0, 0, 1, 15);
    drive(0, 0, 0, 1, 10);
    drive(0, 0, 0, 1, 9);
    drive(0, 0, 0, 0, 0);

    // Gapped enables and a load in mid-phase.
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 1, 3);
    for (int k = 0; k < 8; k++) drive(1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      bit re, ru, rc, rl;
      re = ($urandom_range(0, 99) < 80);
      ru = ($urandom_range(0, 99) < 55);
      rc = ($urandom_range(0, 99) < 3);
      rl = ($urandom_range(0, 99) < 5);
      drive(re, ru, rc, rl, int'($urandom_range(0, 15)));
    end

    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
